// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: per-tile control of the weight BRAM address generator,
// the ifmaps preload FIFO and the MAC array partial-sum drain.
// Optional drain watchdog enabled by defining MAC_SEQ_WDOG_EN.

module mac_tile_sequencer #(
  parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
  parameter int unsigned TILE_CNT_WIDTH     = 16,
  parameter int unsigned WDOG_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic [TILE_CNT_WIDTH-1:0]     cfg_tile_count,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] cfg_rows_per_tile,
  input  logic [WDOG_WIDTH-1:0]         cfg_wdog_limit,
  input  logic                          ifmaps_fifo_empty,
  input  logic                          psum_valid,
  output logic                          address_reset,
  output logic                          read_weight,
  output logic                          read_ifmaps,
  output logic                          busy,
  output logic                          done,
  output logic [TILE_CNT_WIDTH-1:0]     tile_idx,
  output logic [1:0]                    err_status
);

  localparam int unsigned AW = BRAM_ADDRESS_WIDTH;
  localparam int unsigned TW = TILE_CNT_WIDTH;
  localparam int unsigned WW = WDOG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  state_e        state_q, state_d;

  logic [AW-1:0] rows_q, rows_d;
  logic [TW-1:0] tile_cnt_q, tile_cnt_d;
  logic [TW-1:0] tile_idx_q, tile_idx_d;
  logic [AW-1:0] issue_q, issue_d;
  logic [AW-1:0] ret_q, ret_d;
  logic [1:0]    err_q, err_d;

  logic          beat;
  logic          start_acc;
  logic          cfg_is_empty;
  logic          last_issue;
  logic          ret_full;
  logic          last_tile;
  logic          psum_window;
  logic          wdog_hit;

  // A start is only taken in IDLE and loses against a simultaneous abort
  assign start_acc    = (state_q == S_IDLE) && cfg_start && !cfg_abort;
  assign cfg_is_empty = (cfg_tile_count == '0) || (cfg_rows_per_tile == '0);
  assign last_issue   = (issue_q == (rows_q - AW'(1)));
  assign ret_full     = (ret_q == rows_q);
  assign last_tile    = (tile_idx_q == (tile_cnt_q - TW'(1)));
  assign psum_window  = (state_q == S_STREAM) || (state_q == S_DRAIN);

`ifdef MAC_SEQ_WDOG_EN
  logic [WW-1:0] wdog_q, wdog_d;
  logic [WW-1:0] wdog_lim_q, wdog_lim_d;

  // Timeout fires on the cycle that would bring the idle count up to the limit
  assign wdog_hit = (state_q == S_DRAIN) && !psum_valid && !ret_full &&
                    (wdog_lim_q != '0) && ((wdog_q + WW'(1)) == wdog_lim_q);

  // Watchdog count and latched limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q     <= '0;
      wdog_lim_q <= '0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_lim_q <= wdog_lim_d;
    end
  end

  // Watchdog next state: held at zero until DRAIN, restarts on every return
  always_comb begin
    wdog_d     = wdog_q;
    wdog_lim_d = wdog_lim_q;
    if (start_acc) begin
      wdog_lim_d = cfg_wdog_limit;
    end
    if (state_q == S_DRAIN) begin
      wdog_d = psum_valid ? '0 : (wdog_q + WW'(1));
    end else begin
      wdog_d = '0;
    end
  end
`else
  logic unused_wdog_limit;

  assign wdog_hit          = 1'b0;
  assign unused_wdog_limit = ^cfg_wdog_limit;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = cfg_is_empty ? S_FIN : S_CLEAR;
        end
      end
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: begin
        if (beat && last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_full) begin
          state_d = S_NEXT;
        end else if (wdog_hit) begin
          state_d = S_FIN;
        end
      end
      S_NEXT:   state_d = last_tile ? S_FIN : S_CLEAR;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort ends any run in progress; FIN is already on its way out
    if (cfg_abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      state_d = S_FIN;
    end
  end

  // Output decode; reads are gated by FIFO data and by abort in the same cycle
  always_comb begin
    address_reset = 1'b0;
    beat          = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;
    case (state_q)
      S_CLEAR:  address_reset = 1'b1;
      S_STREAM: beat          = !ifmaps_fifo_empty && !cfg_abort;
      S_FIN:    done          = 1'b1;
      default:  ;
    endcase
    busy        = (state_q != S_IDLE);
    read_weight = beat;
    read_ifmaps = beat;
  end

  // Datapath registers: latched config, tile index, beat counters, error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q     <= '0;
      tile_cnt_q <= '0;
      tile_idx_q <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      err_q      <= '0;
    end else begin
      rows_q     <= rows_d;
      tile_cnt_q <= tile_cnt_d;
      tile_idx_q <= tile_idx_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      err_q      <= err_d;
    end
  end

  // Datapath next state
  always_comb begin
    rows_d     = rows_q;
    tile_cnt_d = tile_cnt_q;
    tile_idx_d = tile_idx_q;
    issue_d    = issue_q;
    ret_d      = ret_q;
    err_d      = err_q;

    if (start_acc) begin
      rows_d     = cfg_rows_per_tile;
      tile_cnt_d = cfg_tile_count;
      tile_idx_d = '0;
      issue_d    = '0;
      ret_d      = '0;
      err_d      = '0;
    end

    if (state_q == S_CLEAR) begin
      issue_d = '0;
      ret_d   = '0;
    end

    if (beat) begin
      issue_d = issue_q + AW'(1);
    end

    if ((state_q == S_NEXT) && (state_d == S_CLEAR)) begin
      tile_idx_d = tile_idx_q + TW'(1);
    end

    // Returns are only legal while a tile is in flight and not yet complete
    if (psum_valid) begin
      if (psum_window && !ret_full) begin
        ret_d = ret_q + AW'(1);
      end else begin
        err_d[0] = 1'b1;
      end
    end

    if (wdog_hit) begin
      err_d[1] = 1'b1;
    end
  end

  assign tile_idx   = tile_idx_q;
  assign err_status = err_q;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed bench for mac_tile_sequencer: a table of whole-run vectors plus
// hand-written sequences for reset, abort, stray returns and drain timeout.

module tb_mac_tile_sequencer;

  localparam int unsigned AW = 12;
  localparam int unsigned TW = 16;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic          cfg_abort;
  logic [TW-1:0] cfg_tile_count;
  logic [AW-1:0] cfg_rows_per_tile;
  logic [WW-1:0] cfg_wdog_limit;
  logic          ifmaps_fifo_empty;
  logic          psum_valid;
  logic          psum_auto;
  logic          psum_man;
  logic          address_reset;
  logic          read_weight;
  logic          read_ifmaps;
  logic          busy;
  logic          done;
  logic [TW-1:0] tile_idx;
  logic [1:0]    err_status;

  assign psum_valid = psum_auto | psum_man;

  always #5 clk = ~clk;

  mac_tile_sequencer #(
    .BRAM_ADDRESS_WIDTH(AW),
    .TILE_CNT_WIDTH    (TW),
    .WDOG_WIDTH        (WW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_tile_count   (cfg_tile_count),
    .cfg_rows_per_tile(cfg_rows_per_tile),
    .cfg_wdog_limit   (cfg_wdog_limit),
    .ifmaps_fifo_empty(ifmaps_fifo_empty),
    .psum_valid       (psum_valid),
    .address_reset    (address_reset),
    .read_weight      (read_weight),
    .read_ifmaps      (read_ifmaps),
    .busy             (busy),
    .done             (done),
    .tile_idx         (tile_idx),
    .err_status       (err_status)
  );

  typedef struct {
    int tc;          // tile count
    int rows;        // rows per tile
    int stall_after; // FIFO goes empty after this many beats (0 = never)
    int stall_len;   // cycles the FIFO stays empty
    int extra_cyc;   // cycle of an extra psum pulse (-1 = none)
    int plim;        // number of reads that get a psum back
    int wlim;        // watchdog limit
    int e_ar;        // expected address_reset pulses
    int e_rd;        // expected read beats
    int e_dcyc;      // expected cycle of done (start cycle = 0)
    int e_err;       // expected err_status after the run
    int e_tidx;      // expected final tile_idx
  } vec_t;

  vec_t vt[$];

  int n_vec = 0;
  int n_err = 0;

  // run-time bookkeeping
  logic [2:0] sh;
  int cyc, done_cyc, stall_cnt, stall_after, stall_len, extra_cyc, psum_lim;
  int rd_tot, ar_tot, done_tot, busy_tot, viol;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_counts();
    sh = '0; cyc = 0; done_cyc = -1; stall_cnt = 0; stall_after = 0;
    stall_len = 0; extra_cyc = -1; psum_lim = 1000;
    rd_tot = 0; ar_tot = 0; done_tot = 0; busy_tot = 0; viol = 0;
  endtask

  // Mid-cycle observation; also feeds the 3-cycle MAC latency pipe
  task automatic sample();
    @(negedge clk);
    if ((read_weight !== read_ifmaps) || (read_weight && ifmaps_fifo_empty)) viol++;
    if (address_reset) ar_tot++;
    if (busy) busy_tot++;
    if (done) begin
      done_tot++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (read_weight) begin
      rd_tot++;
      if (rd_tot == stall_after) stall_cnt = stall_len;
    end
    sh = {sh[1:0], read_weight && (rd_tot <= psum_lim)};
  endtask

  // Move to just after the next rising edge and drive this cycle's inputs
  task automatic adv();
    @(posedge clk);
    #1;
    psum_auto = sh[2];
    if (stall_cnt > 0) begin
      ifmaps_fifo_empty = 1'b1;
      stall_cnt--;
    end else begin
      ifmaps_fifo_empty = 1'b0;
    end
    cyc++;
    psum_man  = (cyc == extra_cyc);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit fin;
    fin = 1'b0;
    reset_counts();
    stall_after = v.stall_after;
    stall_len   = v.stall_len;
    extra_cyc   = v.extra_cyc;
    psum_lim    = v.plim;
    cfg_tile_count    = TW'(v.tc);
    cfg_rows_per_tile = AW'(v.rows);
    cfg_wdog_limit    = WW'(v.wlim);
    cfg_start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      sample();
      if ((done_cyc >= 0) && (cyc == done_cyc + 1)) begin
        fin = 1'b1;
        break;
      end
      adv();
    end
    check($sformatf("v%0d_addr_reset_count", idx), ar_tot, v.e_ar);
    check($sformatf("v%0d_read_beats", idx), rd_tot, v.e_rd);
    check($sformatf("v%0d_done_count", idx), done_tot, 1);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.e_dcyc);
    check($sformatf("v%0d_busy_cycles", idx), busy_tot, v.e_dcyc);
    check($sformatf("v%0d_err_status", idx), err_status, v.e_err);
    check($sformatf("v%0d_tile_idx", idx), tile_idx, v.e_tidx);
    check($sformatf("v%0d_read_protocol", idx), viol, 0);
    if (fin) adv();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_tile_count = '0;
    cfg_rows_per_tile = '0; cfg_wdog_limit = '0; ifmaps_fifo_empty = 1'b0;
    psum_auto = 1'b0; psum_man = 1'b0;
    reset_counts();

    //            tc rows sa sl  ex  plim wl  ar rd dcyc err tidx
    vt.push_back('{2, 4,  0, 0, -1, 1000, 0,  2, 8, 21,  0,  1});
    vt.push_back('{1, 4,  2, 5, -1, 1000, 0,  1, 4, 16,  0,  0});
    vt.push_back('{0, 4,  0, 0, -1, 1000, 0,  0, 0,  1,  0,  0});
    vt.push_back('{5, 0,  0, 0, -1, 1000, 0,  0, 0,  1,  0,  0});
    vt.push_back('{3, 1,  0, 0, -1, 1000, 0,  3, 3, 22,  0,  2});
    vt.push_back('{1, 4,  0, 0,  9, 1000, 0,  1, 4, 11,  1,  0});
    vt.push_back('{1, 4,  0, 0, -1, 1000, 0,  1, 4, 11,  0,  0});
`ifdef MAC_SEQ_WDOG_EN
    vt.push_back('{1, 4,  0, 0, -1,    3, 10, 1, 4, 18,  2,  0});
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {address_reset, read_weight, read_ifmaps, busy, done, tile_idx, err_status}, 0);
    rst = 1'b0;

    // stray return in IDLE sets a sticky error
    psum_man = 1'b1;
    adv();
    sample();
    check("idle_psum_err", err_status, 1);
    adv(); adv();
    sample();
    check("idle_psum_err_sticky", err_status, 1);
    adv();

    // start together with abort in IDLE: start is dropped
    cfg_tile_count = TW'(1); cfg_rows_per_tile = AW'(4);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    adv();
    sample();
    check("start_abort_idle_busy", busy, 0);
    check("start_abort_idle_err", err_status, 1);
    adv();

    // table: first vector also shows the error being cleared by start
    foreach (vt[i]) run_vec(vt[i], i);

    // abort during STREAM of tile 1 of 3
    reset_counts();
    cfg_tile_count = TW'(3); cfg_rows_per_tile = AW'(4);
    cfg_start = 1'b1;
    for (int k = 0; k < 13; k++) begin
      sample();
      adv();
    end
    cfg_abort = 1'b1;
    sample();
    check("abort_reads_drop", read_weight, 0);
    check("abort_tile_idx", tile_idx, 1);
    check("abort_busy", busy, 1);
    sh = '0;
    adv();
    sample();
    check("abort_done", done, 1);
    adv();
    sample();
    check("abort_busy_after", busy, 0);
    check("abort_err", err_status, 0);
    adv();
    run_vec(vt[6], 100);

    // withheld last return
`ifndef MAC_SEQ_WDOG_EN
    reset_counts();
    psum_lim = 3;
    cfg_tile_count = TW'(1); cfg_rows_per_tile = AW'(4);
    cfg_start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sample();
      adv();
    end
    sample();
    check("nowdog_stuck_done", done_tot, 0);
    check("nowdog_stuck_busy", busy, 1);
    cfg_abort = 1'b1;
    adv();
    sample();
    check("nowdog_abort_done", done, 1);
    check("nowdog_err", err_status, 0);
    adv();
    sample();
    check("nowdog_busy_after", busy, 0);
    adv();
`endif

    // asynchronous reset mid-run
    reset_counts();
    cfg_tile_count = TW'(2); cfg_rows_per_tile = AW'(4);
    cfg_start = 1'b1;
    for (int k = 0; k < 13; k++) begin
      sample();
      adv();
    end
    #3;
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs",
          {address_reset, read_weight, read_ifmaps, busy, done, tile_idx, err_status}, 0);
    reset_counts();
    psum_auto = 1'b0;
    adv();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      adv();
    end
    check("midrun_reset_no_done", done_tot, 0);
    check("midrun_reset_idle", busy_tot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
